// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Pipeline hazard unit for the 5-stage RV32 core. It provides:
//   - EX operand forwarding from MEM/WB, with MEM taking priority
//   - the load-use stall
//   - the jump flush
//   - a per-register pending scoreboard for the out-of-order MDU
//   - an MDU outstanding-op limit
//   - saturating stall counters split by cause
//
// Ports
//   clk, rst_n                       core clock, synchronous active-low reset
//   rs1_id_i, rs2_id_i, rd_id_i      ID source/destination registers
//   use_rs1_id_i, use_rs2_id_i       ID instruction actually reads rs1/rs2
//   reg_write_c_id_i, is_mdu_id_i    ID writes rd / ID is an MDU op
//   rs1_ex_i, rs2_ex_i, rd_ex_i      EX registers
//   jump_c_ex_i                      taken jump/branch resolved in EX
//   wb_data_sel_c_ex_i               bit0 = EX instruction is a load
//   is_mdu_ex_i                      EX instruction issues to the MDU
//   rd_mem_i, reg_write_c_mem_i      MEM destination / write enable
//   rd_wb_i, reg_write_c_wb_i        WB destination / write enable
//   mdu_wb_valid_i, mdu_wb_rd_i      MDU regfile writeback
//   stall_c_if_o, stall_c_if2id_o    hold PC / IF2ID
//   flush_c_if2id_o, flush_c_id2ex_o bubble IF2ID / ID2EX
//   alu_rs{1,2}_data_sel_c_ex_o      EX operand source select
//                                    (0 id2ex_buf, 1 mem_forward, 2 wb_forward)
//   load_stall_cnt_o, mdu_stall_cnt_o  stall cycles by cause
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NREGS   = 32,
  parameter int MDU_OUT = 4,
  parameter int PERF_W  = 32,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     rs1_id_i,
  input  logic [AW-1:0]     rs2_id_i,
  input  logic              use_rs1_id_i,
  input  logic              use_rs2_id_i,
  input  logic [AW-1:0]     rd_id_i,
  input  logic              reg_write_c_id_i,
  input  logic              is_mdu_id_i,
  input  logic [AW-1:0]     rs1_ex_i,
  input  logic [AW-1:0]     rs2_ex_i,
  input  logic [AW-1:0]     rd_ex_i,
  input  logic              jump_c_ex_i,
  input  logic [1:0]        wb_data_sel_c_ex_i,
  input  logic              is_mdu_ex_i,
  input  logic [AW-1:0]     rd_mem_i,
  input  logic              reg_write_c_mem_i,
  input  logic [AW-1:0]     rd_wb_i,
  input  logic              reg_write_c_wb_i,
  input  logic              mdu_wb_valid_i,
  input  logic [AW-1:0]     mdu_wb_rd_i,
  output logic              stall_c_if_o,
  output logic              stall_c_if2id_o,
  output logic              flush_c_if2id_o,
  output logic              flush_c_id2ex_o,
  output logic [1:0]        alu_rs1_data_sel_c_ex_o,
  output logic [1:0]        alu_rs2_data_sel_c_ex_o,
  output logic [PERF_W-1:0] load_stall_cnt_o,
  output logic [PERF_W-1:0] mdu_stall_cnt_o
);

  localparam int CNT_W = $clog2(MDU_OUT + 1);

  localparam logic [1:0] SEL_ID2EX = 2'd0;
  localparam logic [1:0] SEL_MEM   = 2'd1;
  localparam logic [1:0] SEL_WB    = 2'd2;

  logic [NREGS-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [PERF_W-1:0] load_cnt_q, load_cnt_d;
  logic [PERF_W-1:0] mdu_cnt_q, mdu_cnt_d;

  logic load_stall, sb_stall, cap_stall, stall;

  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs);
    if (rs != '0 && reg_write_c_mem_i && rs == rd_mem_i)     return SEL_MEM;
    else if (rs != '0 && reg_write_c_wb_i && rs == rd_wb_i)  return SEL_WB;
    else                                                     return SEL_ID2EX;
  endfunction

  function automatic logic hit(input logic [AW-1:0] r, input logic use_r,
                               input logic [AW-1:0] target);
    return (r != '0) && use_r && (r == target);
  endfunction

  // ---------------------------------------------------------------- hazards
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    load_stall = 1'b0;
    sb_stall   = 1'b0;
    cap_stall  = 1'b0;

    load_stall = wb_data_sel_c_ex_i[0] && (rd_ex_i != '0) &&
                 (hit(rs1_id_i, use_rs1_id_i, rd_ex_i) ||
                  hit(rs2_id_i, use_rs2_id_i, rd_ex_i));

    // pending[0] is held at 0, so x0 never matches here.
    sb_stall = (pending_q[rs1_id_i] && use_rs1_id_i) ||
               (pending_q[rs2_id_i] && use_rs2_id_i) ||
               (pending_q[rd_id_i]  && reg_write_c_id_i) ||
               // An MDU op issuing this cycle is not yet in pending_q.
               (is_mdu_ex_i && (rd_ex_i != '0) &&
                (hit(rs1_id_i, use_rs1_id_i, rd_ex_i) ||
                 hit(rs2_id_i, use_rs2_id_i, rd_ex_i) ||
                 hit(rd_id_i, reg_write_c_id_i, rd_ex_i)));

    cap_stall = is_mdu_id_i &&
                (((CNT_W+1)'(out_cnt_q) + (CNT_W+1)'(is_mdu_ex_i)) >= (CNT_W+1)'(MDU_OUT));

    // A taken jump kills the ID instruction, so it never needs to wait.
    stall = (load_stall || sb_stall || cap_stall) && !jump_c_ex_i;
  end

  assign stall_c_if_o            = stall;
  assign stall_c_if2id_o         = stall;
  assign flush_c_if2id_o         = jump_c_ex_i;
  assign flush_c_id2ex_o         = jump_c_ex_i | stall;
  assign alu_rs1_data_sel_c_ex_o = fwd_sel(rs1_ex_i);
  assign alu_rs2_data_sel_c_ex_o = fwd_sel(rs2_ex_i);
  assign load_stall_cnt_o        = load_cnt_q;
  assign mdu_stall_cnt_o         = mdu_cnt_q;

  // ------------------------------------------------------------ next state
  always_comb begin
    pending_d  = pending_q;
    out_cnt_d  = out_cnt_q;
    load_cnt_d = load_cnt_q;
    mdu_cnt_d  = mdu_cnt_q;

    // Clear first so that a same-cycle issue to the same register wins.
    if (mdu_wb_valid_i)                 pending_d[mdu_wb_rd_i] = 1'b0;
    if (is_mdu_ex_i && rd_ex_i != '0)   pending_d[rd_ex_i]     = 1'b1;
    pending_d[0] = 1'b0;

    // Issue and writeback in the same cycle cancel out. Decrement at 0 is a
    // protocol error and is absorbed.
    if (is_mdu_ex_i && !mdu_wb_valid_i) begin
      if (out_cnt_q < CNT_W'(MDU_OUT)) out_cnt_d = out_cnt_q + CNT_W'(1);
    end else if (!is_mdu_ex_i && mdu_wb_valid_i) begin
      if (out_cnt_q != '0) out_cnt_d = out_cnt_q - CNT_W'(1);
    end

    if (stall && load_stall && !(&load_cnt_q))
      load_cnt_d = load_cnt_q + PERF_W'(1);
    if (stall && (sb_stall || cap_stall) && !load_stall && !(&mdu_cnt_q))
      mdu_cnt_d = mdu_cnt_q + PERF_W'(1);
  end

  // NOTE: state uses non-blocking assignments and a synchronous reset; the
  // reset branch overrides everything, so MDU writebacks during reset are lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q  <= '0;
      out_cnt_q  <= '0;
      load_cnt_q <= '0;
      mdu_cnt_q  <= '0;
    end else begin
      pending_q  <= pending_d;
      out_cnt_q  <= out_cnt_d;
      load_cnt_q <= load_cnt_d;
      mdu_cnt_q  <= mdu_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Directed vectors for hazard_scoreboard (MDU_OUT = 2). Each vector drives
//   the inputs just after a rising edge and queues the hand-computed outputs;
//   a monitor pops the queue on the falling edge and compares.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_id, rs2_id, rd_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb, mdu_wb_rd;
  logic        use_rs1_id, use_rs2_id, reg_write_c_id, is_mdu_id;
  logic        jump_c_ex, is_mdu_ex, reg_write_c_mem, reg_write_c_wb, mdu_wb_valid;
  logic [1:0]  wb_data_sel_c_ex;
  logic        stall_c_if, stall_c_if2id, flush_c_if2id, flush_c_id2ex;
  logic [1:0]  sel1, sel2;
  logic [31:0] load_cnt, mdu_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREGS(32), .MDU_OUT(2), .PERF_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_id_i(rs1_id), .rs2_id_i(rs2_id),
    .use_rs1_id_i(use_rs1_id), .use_rs2_id_i(use_rs2_id),
    .rd_id_i(rd_id), .reg_write_c_id_i(reg_write_c_id), .is_mdu_id_i(is_mdu_id),
    .rs1_ex_i(rs1_ex), .rs2_ex_i(rs2_ex), .rd_ex_i(rd_ex),
    .jump_c_ex_i(jump_c_ex), .wb_data_sel_c_ex_i(wb_data_sel_c_ex), .is_mdu_ex_i(is_mdu_ex),
    .rd_mem_i(rd_mem), .reg_write_c_mem_i(reg_write_c_mem),
    .rd_wb_i(rd_wb), .reg_write_c_wb_i(reg_write_c_wb),
    .mdu_wb_valid_i(mdu_wb_valid), .mdu_wb_rd_i(mdu_wb_rd),
    .stall_c_if_o(stall_c_if), .stall_c_if2id_o(stall_c_if2id),
    .flush_c_if2id_o(flush_c_if2id), .flush_c_id2ex_o(flush_c_id2ex),
    .alu_rs1_data_sel_c_ex_o(sel1), .alu_rs2_data_sel_c_ex_o(sel2),
    .load_stall_cnt_o(load_cnt), .mdu_stall_cnt_o(mdu_cnt)
  );

  typedef struct {
    string       name;
    logic        stall;
    logic        fl_if2id;
    logic        fl_id2ex;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [31:0] lc;
    logic [31:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compares whatever the stimulus queued for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".stall_if"},    32'(stall_c_if),    32'(e.stall));
      check({e.name, ".stall_if2id"}, 32'(stall_c_if2id), 32'(e.stall));
      check({e.name, ".flush_if2id"}, 32'(flush_c_if2id), 32'(e.fl_if2id));
      check({e.name, ".flush_id2ex"}, 32'(flush_c_id2ex), 32'(e.fl_id2ex));
      check({e.name, ".sel1"},        32'(sel1),          32'(e.s1));
      check({e.name, ".sel2"},        32'(sel2),          32'(e.s2));
      check({e.name, ".load_cnt"},    load_cnt,           e.lc);
      check({e.name, ".mdu_cnt"},     mdu_cnt,            e.mc);
    end
  end

  task automatic idle();
    rs1_id = 0; rs2_id = 0; rd_id = 0; use_rs1_id = 0; use_rs2_id = 0;
    reg_write_c_id = 0; is_mdu_id = 0;
    rs1_ex = 0; rs2_ex = 0; rd_ex = 0; jump_c_ex = 0; wb_data_sel_c_ex = 2'b00; is_mdu_ex = 0;
    rd_mem = 0; reg_write_c_mem = 0; rd_wb = 0; reg_write_c_wb = 0;
    mdu_wb_valid = 0; mdu_wb_rd = 0;
  endtask

  // Queue the expectation for the vector currently driven, then advance.
  task automatic expect_tick(input string n, input logic st, input logic jmp,
                             input logic [1:0] a, input logic [1:0] b,
                             input int lc, input int mc);
    exp_t e;
    e.name = n; e.stall = st; e.fl_if2id = jmp; e.fl_id2ex = jmp | st;
    e.s1 = a; e.s2 = b; e.lc = 32'(lc); e.mc = 32'(mc);
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    expect_tick("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Forwarding
    idle(); rs1_ex = 5; rd_mem = 5; reg_write_c_mem = 1; rd_wb = 5; reg_write_c_wb = 1;
    expect_tick("fwd_mem", 0, 0, 1, 0, 0, 0);
    idle(); rs1_ex = 5; rs2_ex = 5; rd_mem = 5; rd_wb = 5; reg_write_c_wb = 1;
    expect_tick("fwd_wb", 0, 0, 2, 2, 0, 0);
    idle(); rs1_ex = 0; rs2_ex = 5; rd_mem = 5; reg_write_c_mem = 1; rd_wb = 0; reg_write_c_wb = 1;
    expect_tick("fwd_x0", 0, 0, 0, 1, 0, 0);

    // Load-use
    idle(); wb_data_sel_c_ex = 2'b01; rd_ex = 7; rs2_id = 7; use_rs2_id = 1;
    expect_tick("load_use", 1, 0, 0, 0, 0, 0);
    idle();
    expect_tick("load_cnt", 0, 0, 0, 0, 1, 0);
    idle(); wb_data_sel_c_ex = 2'b01; rd_ex = 7; rs2_id = 7; use_rs2_id = 0;
    expect_tick("load_unused", 0, 0, 0, 0, 1, 0);

    // MDU RAW and WAW
    idle(); is_mdu_ex = 1; rd_ex = 9; rs1_id = 9; use_rs1_id = 1;
    expect_tick("mdu_issue", 1, 0, 0, 0, 1, 0);
    idle(); rs1_id = 9; use_rs1_id = 1;
    expect_tick("mdu_raw", 1, 0, 0, 0, 1, 1);
    idle(); rs1_id = 9; use_rs1_id = 1; mdu_wb_valid = 1; mdu_wb_rd = 9;
    expect_tick("mdu_wb", 1, 0, 0, 0, 1, 2);
    idle(); rs1_id = 9; use_rs1_id = 1;
    expect_tick("mdu_released", 0, 0, 0, 0, 1, 3);
    idle(); is_mdu_ex = 1; rd_ex = 4;
    expect_tick("waw_issue", 0, 0, 0, 0, 1, 3);
    idle(); rd_id = 4; reg_write_c_id = 1;
    expect_tick("waw", 1, 0, 0, 0, 1, 3);
    idle(); rs1_id = 4; rd_id = 4; mdu_wb_valid = 1; mdu_wb_rd = 4;
    expect_tick("waw_unused", 0, 0, 0, 0, 1, 4);

    // Outstanding cap (MDU_OUT = 2)
    idle(); is_mdu_ex = 1; rd_ex = 10; is_mdu_id = 1; rd_id = 11; reg_write_c_id = 1;
    expect_tick("cap_issue1", 0, 0, 0, 0, 1, 4);
    idle(); is_mdu_ex = 1; rd_ex = 11; is_mdu_id = 1; rd_id = 12; reg_write_c_id = 1;
    expect_tick("cap_issue2", 1, 0, 0, 0, 1, 4);
    idle(); is_mdu_id = 1; rd_id = 12; reg_write_c_id = 1;
    expect_tick("cap_hold", 1, 0, 0, 0, 1, 5);
    idle(); is_mdu_id = 1; rd_id = 12; reg_write_c_id = 1; mdu_wb_valid = 1; mdu_wb_rd = 10;
    expect_tick("cap_wb", 1, 0, 0, 0, 1, 6);
    idle(); is_mdu_id = 1; rd_id = 12; reg_write_c_id = 1;
    expect_tick("cap_free", 0, 0, 0, 0, 1, 7);
    idle(); is_mdu_ex = 1; rd_ex = 12;
    expect_tick("cap_issue3", 0, 0, 0, 0, 1, 7);
    idle(); is_mdu_ex = 1; rd_ex = 13; mdu_wb_valid = 1; mdu_wb_rd = 11;
    expect_tick("cap_swap", 0, 0, 0, 0, 1, 7);
    idle(); is_mdu_id = 1; rd_id = 14; reg_write_c_id = 1;
    expect_tick("cap_full", 1, 0, 0, 0, 1, 7);
    idle(); mdu_wb_valid = 1; mdu_wb_rd = 12;
    expect_tick("cap_drain1", 0, 0, 0, 0, 1, 8);
    idle(); mdu_wb_valid = 1; mdu_wb_rd = 13;
    expect_tick("cap_drain2", 0, 0, 0, 0, 1, 8);
    idle(); is_mdu_id = 1; rd_id = 14; reg_write_c_id = 1;
    rs1_id = 12; use_rs1_id = 1; rs2_id = 13; use_rs2_id = 1;
    expect_tick("cap_after", 0, 0, 0, 0, 1, 8);

    // Jump during stall
    idle(); wb_data_sel_c_ex = 2'b01; rd_ex = 7; rs1_id = 7; use_rs1_id = 1; jump_c_ex = 1;
    expect_tick("jump_stall", 0, 1, 0, 0, 1, 8);
    idle();
    expect_tick("jump_cnt", 0, 0, 0, 0, 1, 8);

    // Set/clear collision, then reset with pending bits set
    idle(); is_mdu_ex = 1; rd_ex = 3; mdu_wb_valid = 1; mdu_wb_rd = 3;
    expect_tick("collide", 0, 0, 0, 0, 1, 8);
    idle(); rs2_id = 3; use_rs2_id = 1;
    expect_tick("collide_pend", 1, 0, 0, 0, 1, 8);
    idle(); is_mdu_ex = 1; rd_ex = 6; rs2_id = 3; use_rs2_id = 1;
    expect_tick("pend_more", 1, 0, 0, 0, 1, 9);
    rst_n = 1'b0;
    idle(); rs2_id = 3; use_rs2_id = 1; mdu_wb_valid = 1; mdu_wb_rd = 3;
    expect_tick("reset_mid", 1, 0, 0, 0, 1, 10);
    rst_n = 1'b1;
    idle(); rs1_id = 3; use_rs1_id = 1; rs2_id = 6; use_rs2_id = 1;
    expect_tick("after_reset", 0, 0, 0, 0, 0, 0);
    idle(); is_mdu_ex = 1; rd_ex = 20; is_mdu_id = 1; rd_id = 5; reg_write_c_id = 1;
    expect_tick("after_reset_cnt", 0, 0, 0, 0, 0, 0);
    idle();

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
